// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int DIV_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand/result valid-ready handshake bundle for the divider
// Ports: in_valid/in_ready/dividend/divisor (request), out_valid/out_ready/quotient/remainder/ovf (result)
interface seq_restoring_divider_if #(parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT);
  logic in_valid, in_ready, out_valid, out_ready, ovf;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor, quotient, remainder;
  modport master(output in_valid, dividend, divisor, out_ready, input in_ready, out_valid, quotient, remainder, ovf);
  modport slave(input in_valid, dividend, divisor, out_ready, output in_ready, out_valid, quotient, remainder, ovf);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on partial remainder r and shifting quotient q
// Ports: r, q, d in; r_next, q_next out
module div_step #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] rs;
  logic ge;
  // the shifted remainder is W+1 bits wide; only its low W bits survive either branch
  assign rs = {r, q[WIDTH-1]};
  assign ge = rs >= {1'b0, d};
  assign r_next = ge ? rs[WIDTH-1:0] - d : rs[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential unsigned restoring divider, 2W-bit dividend / W-bit divisor, one quotient bit per clock
// Ports: clk, rst (async active-high), bus (slave modport of seq_restoring_divider_if)
// Optional: define DIV_OVF_DETECT_EN to flag overflow/divide-by-zero at accept and skip the iteration
module seq_restoring_divider
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH_DEFAULT) (
  input logic clk,
  input logic rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state, state_next;
  logic [WIDTH-1:0] r, q, d, r_step, q_step;
  logic [CW-1:0] cnt;
  logic accept, last, ovf_in, ovf_q;
  assign accept = bus.in_valid && state == IDLE;
  assign last = cnt == CW'(WIDTH - 1);
`ifdef DIV_OVF_DETECT_EN
  assign ovf_in = bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor;
`else
  assign ovf_in = 1'b0;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (.r(r), .q(q), .d(d), .r_next(r_step), .q_next(q_step));
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = accept ? (ovf_in ? DONE : CALC) : IDLE;
    else if (state == CALC) state_next = last ? DONE : CALC;
    else state_next = bus.out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      r <= ovf_in ? bus.dividend[WIDTH-1:0] : bus.dividend[2*WIDTH-1:WIDTH];
      q <= ovf_in ? '1 : bus.dividend[WIDTH-1:0];
      d <= bus.divisor;
      cnt <= '0;
      ovf_q <= ovf_in;
    end else if (state == CALC) begin
      r <= r_step;
      q <= q_step;
      cnt <= cnt + 1'b1;
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = q;
  assign bus.remainder = r;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard-driven self-checking bench for seq_restoring_divider at WIDTH=4
module tb_seq_restoring_divider;
  localparam int W = 4;
`ifdef DIV_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic ovf;
    int lat;
    bit exact;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  seq_restoring_divider_if #(.WIDTH(W)) bus ();
  seq_restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t model(logic [2*W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.lat = W;
    e.ovf = 1'b0;
    e.exact = 1'b1;
    e.q = '0;
    e.r = '0;
    if (a[2*W-1:W] >= b) begin
      e.exact = OVF_EN;
      e.ovf = OVF_EN;
      e.lat = OVF_EN ? 1 : W;
      e.q = '1;
      e.r = a[W-1:0];
    end else begin
      e.q = W'(a / b);
      e.r = W'(a % b);
    end
    return e;
  endfunction

  task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 50 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_wait: in_ready=%0b required 1 within 50 cycles", bus.in_ready);
    end
    bus.dividend = a;
    bus.divisor = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(a, b));
  endtask

  task automatic wait_result(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.out_valid;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total += 5;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    if (bus.quotient !== 4'd0) begin bad++; $display("FAIL rst_quotient: got %0d want 0", bus.quotient); end
    if (bus.remainder !== 4'd0) begin bad++; $display("FAIL rst_remainder: got %0d want 0", bus.remainder); end
    if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", bus.ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int lat;
    bit got;
    send(a, b);
    e = sb.pop_front();
    wait_result(lat, got);
    total++;
    if (!got || bus.ovf !== e.ovf || lat != e.lat || (e.exact && {bus.quotient, bus.remainder} !== {e.q, e.r})) begin
      bad++;
      $display("FAIL %s %0d/%0d: got valid=%0b q=%0d r=%0d ovf=%0b lat=%0d want q=%0d r=%0d ovf=%0b lat=%0d",
               name, a, b, got, bus.quotient, bus.remainder, bus.ovf, lat, e.q, e.r, e.ovf, e.lat);
    end
    release_result();
  endtask

  task automatic test_basic();
    run_check("basic", 8'd100, 4'd7);
    run_check("basic", 8'd225, 4'd15);
    run_check("basic", 8'd0, 4'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] b, hi, lo;
      b = W'($urandom_range(1, 15));
      hi = W'($urandom_range(0, int'(b) - 1));
      lo = W'($urandom_range(0, 15));
      run_check("random", {hi, lo}, b);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int lat;
    bit got;
    send(8'd100, 4'd7);
    e = sb.pop_front();
    wait_result(lat, got);
    total++;
    if (!got || lat != e.lat || {bus.quotient, bus.remainder, bus.ovf} !== {e.q, e.r, e.ovf}) begin
      bad++;
      $display("FAIL hold_first: got valid=%0b q=%0d r=%0d ovf=%0b lat=%0d want q=%0d r=%0d ovf=%0b lat=%0d",
               got, bus.quotient, bus.remainder, bus.ovf, lat, e.q, e.r, e.ovf, e.lat);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf} !== {1'b1, 1'b0, e.q, e.r, e.ovf}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%0b in_ready=%0b q=%0d r=%0d ovf=%0b want 1 0 %0d %0d %0b",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf, e.q, e.r, e.ovf);
      end
    end
    release_result();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got in_ready=%0b out_valid=%0b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_ignore();
    exp_t e;
    int lat;
    bit got;
    send(8'd100, 4'd7);
    e = sb.pop_front();
    bus.dividend = 8'd200;
    bus.divisor = 4'd9;
    bus.in_valid = 1'b1;
    wait_result(lat, got);
    bus.in_valid = 1'b0;
    total++;
    if (!got || lat != 4 || {bus.quotient, bus.remainder, bus.ovf} !== {4'd14, 4'd2, 1'b0}) begin
      bad++;
      $display("FAIL ignore: got valid=%0b q=%0d r=%0d ovf=%0b lat=%0d want q=14 r=2 ovf=0 lat=4",
               got, bus.quotient, bus.remainder, bus.ovf, lat);
    end
    release_result();
  endtask

  task automatic test_abort();
    int seen;
    send(8'd100, 4'd7);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: got in_ready=%0b out_valid=%0b want 1 0", bus.in_ready, bus.out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    run_check("abort_next", 8'd50, 4'd6);
  endtask

  task automatic test_ovf();
    run_check("ovf", 8'h70, 4'd7);
    run_check("ovf", 8'd5, 4'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_random();
    test_hold();
    test_ignore();
    test_abort();
    test_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
